// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes, FSM states, default width.
package md_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0,
    MD_MULT = 3'd1,
    MD_DIV  = 3'd2,
    MD_MTHI = 3'd3,
    MD_MTLO = 3'd4
  } md_func_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_e;

  function automatic logic is_multi_cycle(input logic [2:0] func);
    return (func == MD_MULT) || (func == MD_DIV);
  endfunction

endpackage

// File: rtl/md_signfix.sv
// Conditional two's-complement negate; serves both as operand abs() and as result sign fixup.
module md_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  always_comb begin
    if (neg_i) begin
      res_o = ~val_i + {{(W-1){1'b0}}, 1'b1};
    end else begin
      res_o = val_i;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Iterative multiply / restoring divide sequencer owning HI/LO. Magnitudes are computed over
// WIDTH CALC cycles, then one FIXUP cycle restores signs and commits HI/LO.
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       func_i,
  input  logic             sign_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               go_s;
  logic               is_mul_s;
  logic               is_div_s;
  logic               is_mthi_s;
  logic               is_mtlo_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  always_comb begin
    is_mul_s  = 1'b0;
    is_div_s  = 1'b0;
    is_mthi_s = 1'b0;
    is_mtlo_s = 1'b0;
    case (func_i)
      MD_MULT: is_mul_s  = 1'b1;
      MD_DIV:  is_div_s  = 1'b1;
      MD_MTHI: is_mthi_s = 1'b1;
      MD_MTLO: is_mtlo_s = 1'b1;
      default: is_mul_s  = 1'b0;
    endcase
  end

  assign go_s   = start_i & ~cancel_i & (state_q == ST_IDLE);
  assign busy_o = ~rst & ((state_q != ST_IDLE) | (start_i & ~cancel_i & is_multi_cycle(func_i)));
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  md_signfix #(.W(WIDTH)) u_abs_a (.val_i(a_i), .neg_i(sign_i & a_i[WIDTH-1]), .res_o(abs_a_s));
  md_signfix #(.W(WIDTH)) u_abs_b (.val_i(b_i), .neg_i(sign_i & b_i[WIDTH-1]), .res_o(abs_b_s));

  md_signfix #(.W(2*WIDTH)) u_fix_prod (.val_i(acc_q), .neg_i(neg_res_q), .res_o(prod_fix_s));
  md_signfix #(.W(WIDTH)) u_fix_quo (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .res_o(quo_fix_s));
  md_signfix #(.W(WIDTH)) u_fix_rem (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q),
                                     .res_o(rem_fix_s));

  // acc_q holds {partial, multiplier} for mult and {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    rem_sh_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff_s    = rem_sh_s - {1'b0, opnd_q};
    if (!is_div_q) begin
      acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end else if (!diff_s[WIDTH]) begin
      acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sequencer FSM, iteration counter, datapath registers and HI/LO commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go_s && (is_mul_s || is_div_s)) begin
            acc_q     <= {{WIDTH{1'b0}}, (is_div_s ? abs_a_s : abs_b_s)};
            opnd_q    <= is_div_s ? abs_b_s : abs_a_s;
            is_div_q  <= is_div_s;
            neg_res_q <= sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_rem_q <= sign_i & a_i[WIDTH-1];
            div0_q    <= is_div_s & (b_i == {WIDTH{1'b0}});
            cnt_q     <= CNT_W'(WIDTH - 1);
            state_q   <= ST_CALC;
          end else if (go_s && is_mthi_s) begin
            hi_q <= a_i;
          end else if (go_s && is_mtlo_s) begin
            lo_q <= a_i;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= ST_FIXUP;
          end else begin
            state_q <= ST_CALC;
          end
        end
        ST_FIXUP: begin
          // Divide-by-zero keeps the natural remainder (the dividend) but forces an all-ones quotient.
          if (is_div_q) begin
            hi_q <= rem_fix_s;
            lo_q <= div0_q ? {WIDTH{1'b1}} : quo_fix_s;
          end else begin
            hi_q <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix_s[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: directed ops push expected HI/LO and completion cycle,
// an independent monitor checks every done_o pulse against the queue.
module tb_md_sequencer;
  import md_pkg::*;

  localparam int W = 32;
  localparam int LAT = 34;

  typedef struct {
    int          cyc;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [2:0]   func_i = 3'd0;
  logic         sign_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cancel_i = 1'b0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  md_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .func_i(func_i), .sign_i(sign_i),
    .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done_o === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_done: got done_o=1, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (hi_o !== e.hi || lo_o !== e.lo || cyc != e.cyc) begin
          n_miss++;
          $display("FAIL sb_result: got hi=0x%08h lo=0x%08h at cycle %0d, expected hi=0x%08h lo=0x%08h at cycle %0d",
                   hi_o, lo_o, cyc, e.hi, e.lo, e.cyc);
        end
      end
    end
  end

  // Issue MULT/DIV at posedge+1 of cycle t, check busy over t..t+33 and low at t+34.
  // With glitch set, a stray start_i is pulsed mid-CALC and must be ignored.
  task automatic run_md(input string name, input logic [2:0] f, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input bit glitch);
    exp_t e;
    int   bad;
    bad = 0;
    start_i = 1'b1; func_i = f; sign_i = s; a_i = a; b_i = b;
    e.cyc = cyc + LAT; e.hi = ehi; e.lo = elo;
    sb_q.push_back(e);
    #1;
    if (busy_o !== 1'b1) bad++;
    @(posedge clk); #1;
    start_i = 1'b0;
    #1;
    for (int k = 1; k < LAT; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (glitch && k == 10) begin
        start_i = 1'b1; func_i = MD_DIV; sign_i = 1'b0; a_i = 32'd5; b_i = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      #1;
      if (busy_o !== 1'b1) bad++;
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    chk({name, "_busy_window"}, 64'(bad), 64'd0);
    chk({name, "_busy_low"}, 64'(busy_o), 64'd0);
  endtask

  // Single-cycle MTHI/MTLO (or a cancelled/NONE issue); busy_o must stay low, state checked after edge.
  task automatic run_mt(input string name, input logic [2:0] f, input logic c, input logic [W-1:0] a,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    start_i = 1'b1; func_i = f; sign_i = 1'b0; a_i = a; b_i = 32'hFFFF_FFFF; cancel_i = c;
    #1;
    chk({name, "_busy"}, 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    chk({name, "_hilo"}, {hi_o, lo_o}, {ehi, elo});
  endtask

  initial begin
    #1;
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_md("mult_s_neg3x5", MD_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_md("multu_max", MD_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_md("mult_s_negneg", MD_MULT, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15, 1'b0);
    run_md("div_s_neg7by2", MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md("div_s_7byneg2", MD_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_md("divu_100by7", MD_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_md("divu_by_zero", MD_DIV, 1'b0, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b0);
    run_md("div_s_neg9by0", MD_DIV, 1'b1, 32'hFFFF_FFF7, 32'h0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b0);
    run_md("div_s_minbyneg1", MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

    run_mt("mthi", MD_MTHI, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h8000_0000);
    run_mt("mtlo", MD_MTLO, 1'b0, 32'h0000_0011, 32'hA5A5_A5A5, 32'h0000_0011);
    run_md("mult_after_mtlo", MD_MULT, 1'b0, 32'h10, 32'h3, 32'h0, 32'h30, 1'b0);

    run_mt("cancel_mult", MD_MULT, 1'b1, 32'h7, 32'h0, 32'h30);
    run_mt("func_none", MD_NONE, 1'b0, 32'h7, 32'h0, 32'h30);
    run_mt("func_undef", 3'd6, 1'b0, 32'h7, 32'h0, 32'h30);
    repeat (LAT + 2) @(posedge clk);
    #1;
    run_md("mult_glitch", MD_MULT, 1'b0, 32'd1000, 32'd1000, 32'h0, 32'd1000000, 1'b1);

    start_i = 1'b1; func_i = MD_DIV; sign_i = 1'b0; a_i = 32'd99; b_i = 32'd4;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_md("mult_after_rst", MD_MULT, 1'b0, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);

    repeat (LAT + 4) @(posedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
